flame_ctrl: RTL

- Schedules bomb-explosion flames and shares the single flame sprite renderer among up to NSLOTS concurrent explosions.
- Accepts detonation requests (screen position) over a valid/ready handshake and holds each in a slot.
- Steps each slot's animation frame (sprite_num) on vertical-frame ticks and frees the slot after the last frame.
- For the current VGA spot, it selects which active slot drives the renderer's centerXF/centerYF/sprite_num.

---
 rtl/flame_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/flame_ctrl.sv
// Flame scheduler: holds up to NSLOTS explosions, steps their animation on frame ticks,
// and muxes the highest-priority flame under the current VGA spot onto the sprite renderer.
module flame_ctrl #(
   parameter int unsigned NSLOTS      = 4,
   parameter int unsigned NFRAMES     = 4,
   parameter int unsigned FRAME_TICKS = 6,
   parameter int unsigned SIZE        = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_tick,
   input  logic                     clear_all,
   input  logic                     req_valid,
   input  logic signed [10:0]       req_x,
   input  logic signed [10:0]       req_y,
   output logic                     req_ready,
   input  logic signed [10:0]       spotX,
   input  logic signed [10:0]       spotY,
   output logic signed [10:0]       centerXF,
   output logic signed [10:0]       centerYF,
   output logic [1:0]               sprite_num,
   output logic                     flame_hit,
   output logic [NSLOTS-1:0]        active_mask,
   output logic                     busy
);

   typedef enum logic {StIdle, StBurn} slot_state_e;

   localparam logic [7:0]         LastTick  = 8'(FRAME_TICKS - 1);
   localparam logic [1:0]         LastFrame = 2'(NFRAMES - 1);
   localparam logic signed [11:0] Size12    = 12'(SIZE);
   localparam logic signed [10:0] NoCenter  = 11'sh400;

   slot_state_e        state_q [NSLOTS];
   slot_state_e        state_d [NSLOTS];
   logic signed [10:0] x_q     [NSLOTS];
   logic signed [10:0] x_d     [NSLOTS];
   logic signed [10:0] y_q     [NSLOTS];
   logic signed [10:0] y_d     [NSLOTS];
   logic [1:0]         frame_q [NSLOTS];
   logic [1:0]         frame_d [NSLOTS];
   logic [7:0]         tick_q  [NSLOTS];
   logic [7:0]         tick_d  [NSLOTS];

   logic               accept;
   logic               loaded;
   logic [NSLOTS-1:0]  hit;
   logic signed [11:0] sx;
   logic signed [11:0] sy;

   function automatic logic signed [11:0] sext(input logic signed [10:0] v);
      return {v[10], v};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NSLOTS); i++) begin
            state_q[i] <= StIdle;
            x_q[i]     <= '0;
            y_q[i]     <= '0;
            frame_q[i] <= '0;
            tick_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NSLOTS); i++) begin
            state_q[i] <= state_d[i];
            x_q[i]     <= x_d[i];
            y_q[i]     <= y_d[i];
            frame_q[i] <= frame_d[i];
            tick_q[i]  <= tick_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
         active_mask[i] = (state_q[i] == StBurn);
      end
      req_ready = ~&active_mask;
      busy      = |active_mask;
   end

   // Accept target is chosen from slots idle before the edge, so an expiring slot is
   // never reused on the same edge.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      frame_d = frame_q;
      tick_d  = tick_q;
      loaded  = 1'b0;
      accept  = req_valid && req_ready;
      for (int i = 0; i < int'(NSLOTS); i++) begin
         if (clear_all) begin
            state_d[i] = StIdle;
         end else if (state_q[i] == StBurn) begin
            if (frame_tick) begin
               if (tick_q[i] < LastTick) begin
                  tick_d[i] = tick_q[i] + 8'd1;
               end else begin
                  tick_d[i] = '0;
                  if (frame_q[i] == LastFrame) begin
                     state_d[i] = StIdle;
                  end else begin
                     frame_d[i] = frame_q[i] + 2'd1;
                  end
               end
            end
         end else if (accept && !loaded) begin
            state_d[i] = StBurn;
            x_d[i]     = req_x;
            y_d[i]     = req_y;
            frame_d[i] = '0;
            tick_d[i]  = '0;
            loaded     = 1'b1;
         end
      end
   end

   always_comb begin
      sx = sext(spotX);
      sy = sext(spotY);
      for (int i = 0; i < int'(NSLOTS); i++) begin
         hit[i] = active_mask[i]
               && (sx >= sext(x_q[i])) && (sx < sext(x_q[i]) + Size12)
               && (sy >= sext(y_q[i])) && (sy < sext(y_q[i]) + Size12);
      end
   end

   // Scan from the top so the lowest hitting slot is written last and wins.
   always_comb begin
      centerXF   = NoCenter;
      centerYF   = NoCenter;
      sprite_num = '0;
      flame_hit  = 1'b0;
      for (int i = int'(NSLOTS) - 1; i >= 0; i--) begin
         if (hit[i]) begin
            centerXF   = x_q[i];
            centerYF   = y_q[i];
            sprite_num = frame_q[i];
            flame_hit  = 1'b1;
         end
      end
   end

endmodule
